// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter owner and instruction-fetch sequencer for the
// single-cycle core. Fetches one instruction at a time over a req/ack port,
// holds it for execute, then redirects from the jump/branch result.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    input  logic [31:0] if_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic [31:0] jmp_to,
    input  logic [1:0]  jmp_kind,
    input  logic        jmp_taken,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    // GAP is the single idle cycle after a fetch timeout, so memory sees
    // if_req fall and rise again for the request to TRAP_VEC.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] KIND_B    = 2'b00;
    localparam logic [1:0] KIND_JALR = 2'b01;
    localparam logic [1:0] KIND_JAL  = 2'b11;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] seq_pc;
    logic [31:0] tgt_pc;
    logic        misaligned;
    logic        fetch_timeout;
    logic        exec_done;

    assign fetch_timeout = (state == FETCH) && !if_ack && (cnt == CNT_LAST);
    assign exec_done     = (state == EXEC) && !stall;

    // Next-PC selection; bit0 is always cleared, bit1 flags a misaligned target.
    always_comb begin
        seq_pc = pc + 32'd4;
        tgt_pc = seq_pc;
        if (jmp_taken) begin
            case (jmp_kind)
                KIND_JAL, KIND_JALR: tgt_pc = {jmp_to[31:1], 1'b0};
                KIND_B:              tgt_pc = (pc + jmp_to) & 32'hFFFF_FFFE;
                default:             tgt_pc = seq_pc;  // reserved kind
            endcase
        end
        misaligned = tgt_pc[1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next-state logic; an ack on the last wait cycle wins over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (if_ack)             state_nxt = EXEC;
                else if (fetch_timeout) state_nxt = GAP;
            end
            EXEC: begin
                if (!stall) state_nxt = FETCH;
            end
            GAP:     state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Outputs decoded from state; if_addr simply tracks pc.
    always_comb begin
        if_req     = (state == FETCH);
        inst_valid = (state == EXEC);
        if_addr    = pc;
    end

    // Program counter: moves only on EXEC exit, fetch timeout or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (fetch_timeout) begin
            pc <= TRAP_VEC;
        end else if (exec_done) begin
            pc <= misaligned ? TRAP_VEC : tgt_pc;
        end
    end

    // Instruction latch: only an ack while fetching is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst <= '0;
        end else if (state == FETCH && if_ack) begin
            inst <= if_rdata;
        end
    end

    // Wait counter: counts un-acked fetch cycles, cleared on any exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == FETCH && !if_ack && !fetch_timeout) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Trap pulse, registered one cycle after the deciding edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else if (fetch_timeout) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
        end else if (exec_done && misaligned) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_MISALIGN;
        end else begin
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end
    end

endmodule
